// File: rtl/vga_axil_pkg.sv
// Shared definitions for the VGA AXI-Lite native side.
// Register map, CTRL bit indices and colour type.
package vga_axil_pkg;

  localparam int NATIVE_AW = 8;
  typedef logic [NATIVE_AW-1:0] native_addr_t;

  localparam native_addr_t REG_CTRL      = 8'd0;
  localparam native_addr_t REG_BG_COLOR  = 8'd1;
  localparam native_addr_t REG_STATUS    = 8'd2;
  localparam native_addr_t REG_FRAME_CNT = 8'd3;
  localparam native_addr_t REG_SCRATCH   = 8'd4;
  localparam native_addr_t REG_ID        = 8'd5;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_TEST_PAT_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;

  typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/vga_edge_detect.sv
// One-bit rising-edge detector with synchronous reset.
module vga_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/vga_native_regfile.sv
// VGA control/status register file on the AXI-Lite native port.
// Define VGA_REGFILE_IRQ_EN to implement CTRL[2] and the irq output.
module vga_native_regfile
  import vga_axil_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5647_4101
) (
  input  logic         clk,
  input  logic         rst,
  input  native_addr_t addr_write,
  input  logic         write_en,
  input  logic [31:0]  data2native,
  input  native_addr_t addr_read,
  input  logic         read_en_sync,
  output logic [31:0]  data2axil,
  input  logic         vsync,
  output logic         ctrl_enable,
  output logic         ctrl_test_pattern,
  output rgb444_t      bg_color,
  output logic         irq
);

  logic        en_q;
  logic        tp_q;
  logic        irq_en_q;
  rgb444_t     bg_q;
  logic        flag_q;
  logic [31:0] frame_cnt_q;
  logic [31:0] scratch_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        rise;

  logic wr_ctrl, wr_bg, wr_status, wr_scratch;

  assign wr_ctrl    = write_en && (addr_write == REG_CTRL);
  assign wr_bg      = write_en && (addr_write == REG_BG_COLOR);
  assign wr_status  = write_en && (addr_write == REG_STATUS);
  assign wr_scratch = write_en && (addr_write == REG_SCRATCH);

  vga_edge_detect u_vsync_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (vsync),
    .rise_o (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      tp_q        <= 1'b0;
      bg_q        <= '0;
      flag_q      <= 1'b0;
      frame_cnt_q <= '0;
      scratch_q   <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q <= data2native[CTRL_ENABLE_BIT];
        tp_q <= data2native[CTRL_TEST_PAT_BIT];
      end
      if (wr_bg) bg_q <= data2native[11:0];
      if (wr_scratch) scratch_q <= data2native;
      // a rise in the same cycle as a W1C keeps the flag set
      if (rise) flag_q <= 1'b1;
      else if (wr_status && data2native[0]) flag_q <= 1'b0;
      if (rise && en_q) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

`ifdef VGA_REGFILE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= data2native[CTRL_IRQ_EN_BIT];
      irq_q <= flag_q & irq_en_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (addr_read)
      REG_CTRL:      rdata_d = {29'd0, irq_en_q, tp_q, en_q};
      REG_BG_COLOR:  rdata_d = {20'd0, bg_q};
      REG_STATUS:    rdata_d = {30'd0, vsync, flag_q};
      REG_FRAME_CNT: rdata_d = frame_cnt_q;
      REG_SCRATCH:   rdata_d = scratch_q;
      REG_ID:        rdata_d = ID_VALUE;
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)               rdata_q <= '0;
    else if (read_en_sync) rdata_q <= rdata_d;
  end

  assign data2axil         = rdata_q;
  assign ctrl_enable       = en_q;
  assign ctrl_test_pattern = tp_q;
  assign bg_color          = bg_q;

endmodule

// File: tb/tb_vga_native_regfile.sv
// Self-checking bench for vga_native_regfile against a
// register-map level reference model.
module tb_vga_native_regfile;
  import vga_axil_pkg::*;

  localparam logic [31:0] ID = 32'h5647_4101;
`ifdef VGA_REGFILE_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  native_addr_t addr_write = '0;
  logic         write_en = 1'b0;
  logic [31:0]  data2native = '0;
  native_addr_t addr_read = '0;
  logic         read_en_sync = 1'b0;
  logic [31:0]  data2axil;
  logic         vsync = 1'b0;
  logic         ctrl_enable;
  logic         ctrl_test_pattern;
  rgb444_t      bg_color;
  logic         irq;

  int passed = 0;
  int total  = 0;

  // reference model state
  logic [2:0]  m_ctrl;
  logic [11:0] m_bg;
  logic        m_flag;
  logic [31:0] m_cnt;
  logic [31:0] m_scratch;
  logic [31:0] m_rdata;
  logic        m_irq;
  logic        m_vprev;

  vga_native_regfile #(.ID_VALUE(ID)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr_write        (addr_write),
    .write_en          (write_en),
    .data2native       (data2native),
    .addr_read         (addr_read),
    .read_en_sync      (read_en_sync),
    .data2axil         (data2axil),
    .vsync             (vsync),
    .ctrl_enable       (ctrl_enable),
    .ctrl_test_pattern (ctrl_test_pattern),
    .bg_color          (bg_color),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'd0:    return {29'd0, m_ctrl};
      8'd1:    return {20'd0, m_bg};
      8'd2:    return {30'd0, vsync, m_flag};
      8'd3:    return m_cnt;
      8'd4:    return m_scratch;
      8'd5:    return ID;
      default: return 32'd0;
    endcase
  endfunction

  // advance model and DUT by one clock using the currently driven inputs
  task automatic cycle();
    logic rose;
    logic en_before;
    rose = vsync && !m_vprev;
    en_before = m_ctrl[0];
    if (rst) begin
      m_ctrl = 0; m_bg = 0; m_flag = 0; m_cnt = 0;
      m_scratch = 0; m_rdata = 0; m_irq = 0; m_vprev = 0;
    end else begin
      if (read_en_sync) m_rdata = model_read(addr_read);
      m_irq = m_flag & m_ctrl[2];
      if (write_en) begin
        if (addr_write == 8'd0) m_ctrl = data2native[2:0] & CTRL_MASK;
        if (addr_write == 8'd1) m_bg = data2native[11:0];
        if (addr_write == 8'd2 && data2native[0]) m_flag = 1'b0;
        if (addr_write == 8'd4) m_scratch = data2native;
      end
      if (rose) m_flag = 1'b1;
      if (rose && en_before) m_cnt = m_cnt + 1;
      m_vprev = vsync;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    write_en = 1'b1; addr_write = a; data2native = d;
    cycle();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    read_en_sync = 1'b1; addr_read = a;
    cycle();
    read_en_sync = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1; cycle();
    vsync = 1'b0; cycle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_v;
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    total++;
    if ({data2axil, ctrl_enable, ctrl_test_pattern, bg_color, irq} !== '0)
      $display("FAIL reset_outputs: got %h/%b/%b/%h/%b want all 0",
               data2axil, ctrl_enable, ctrl_test_pattern, bg_color, irq);
    else passed++;
    for (int a = 0; a <= 6; a++) begin
      rd(8'(a));
      exp_v = (a == 5) ? 32'h5647_4101 : 32'd0;
      total++;
      if (data2axil !== exp_v || data2axil !== m_rdata)
        $display("FAIL reset_read[%0d]: got %h want %h", a, data2axil, exp_v);
      else passed++;
    end
  endtask

  task automatic test_config();
    wr(8'd0, 32'hFFFF_FFFF);
    wr(8'd1, 32'hFFFF_FABC);
    total++;
    if (ctrl_enable !== 1'b1 || ctrl_test_pattern !== 1'b1 || bg_color !== 12'hABC)
      $display("FAIL cfg_outputs: got %b %b %h want 1 1 abc",
               ctrl_enable, ctrl_test_pattern, bg_color);
    else passed++;
    rd(8'd0);
    total++;
    if (data2axil !== {29'd0, CTRL_MASK})
      $display("FAIL ctrl_read: got %h want %h", data2axil, {29'd0, CTRL_MASK});
    else passed++;
    rd(8'd1);
    total++;
    if (data2axil !== 32'h0000_0ABC)
      $display("FAIL bg_read: got %h want 00000abc", data2axil);
    else passed++;
    // RO registers ignore writes
    wr(8'd5, 32'h1111_2222);
    wr(8'd3, 32'h3333_4444);
    rd(8'd5);
    total++;
    if (data2axil !== ID) $display("FAIL id_ro: got %h want %h", data2axil, ID);
    else passed++;
    rd(8'd3);
    total++;
    if (data2axil !== m_cnt) $display("FAIL cnt_ro: got %h want %h", data2axil, m_cnt);
    else passed++;
  endtask

  task automatic test_frames();
    wr(8'd2, 32'h1);
    for (int i = 0; i < 3; i++) pulse_vsync();
    rd(8'd3);
    total++;
    if (data2axil !== 32'd3) $display("FAIL frame_cnt3: got %h want 3", data2axil);
    else passed++;
    rd(8'd2);
    total++;
    if (data2axil[0] !== 1'b1) $display("FAIL status_set: got %h want bit0=1", data2axil);
    else passed++;
    total++;
    if (irq !== m_irq) $display("FAIL irq_set: got %b want %b", irq, m_irq);
    else passed++;
    wr(8'd2, 32'h1);
    cycle();
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq);
    else passed++;
    rd(8'd2);
    total++;
    if (data2axil[0] !== 1'b0) $display("FAIL status_clear: got %h want bit0=0", data2axil);
    else passed++;
  endtask

  task automatic test_same_cycle();
    wr(8'd4, 32'hDEAD);
    write_en = 1'b1; addr_write = 8'd4; data2native = 32'h1234;
    read_en_sync = 1'b1; addr_read = 8'd4;
    cycle();
    write_en = 1'b0; read_en_sync = 1'b0;
    total++;
    if (data2axil !== 32'hDEAD) $display("FAIL rw_same: got %h want 0000dead", data2axil);
    else passed++;
    cycle();
    total++;
    if (data2axil !== 32'hDEAD) $display("FAIL rdata_hold: got %h want 0000dead", data2axil);
    else passed++;
    rd(8'd4);
    total++;
    if (data2axil !== 32'h1234) $display("FAIL rw_after: got %h want 00001234", data2axil);
    else passed++;
  endtask

  task automatic test_w1c_race();
    logic [31:0] cnt0;
    write_en = 1'b1; addr_write = 8'd2; data2native = 32'h1;
    vsync = 1'b1;
    cycle();
    write_en = 1'b0; vsync = 1'b0;
    rd(8'd2);
    total++;
    if (data2axil[0] !== 1'b1) $display("FAIL w1c_race: got %h want bit0=1", data2axil);
    else passed++;
    wr(8'd2, 32'h1);
    wr(8'd0, 32'h0);
    cnt0 = m_cnt;
    pulse_vsync();
    rd(8'd3);
    total++;
    if (data2axil !== cnt0) $display("FAIL cnt_disabled: got %h want %h", data2axil, cnt0);
    else passed++;
    rd(8'd2);
    total++;
    if (data2axil[0] !== 1'b1) $display("FAIL flag_disabled: got %h want bit0=1", data2axil);
    else passed++;
  endtask

  task automatic test_wrap();
    wr(8'd0, 32'h1);
    dut.frame_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    rd(8'd3);
    total++;
    if (data2axil !== 32'hFFFF_FFFF) $display("FAIL cnt_preload: got %h want ffffffff", data2axil);
    else passed++;
    pulse_vsync();
    rd(8'd3);
    total++;
    if (data2axil !== 32'd0) $display("FAIL cnt_wrap: got %h want 0", data2axil);
    else passed++;
  endtask

  task automatic test_rst_read();
    rd(8'd5);
    read_en_sync = 1'b1; addr_read = 8'd5; rst = 1'b1;
    cycle();
    read_en_sync = 1'b0; rst = 1'b0;
    total++;
    if (data2axil !== 32'd0 || ctrl_enable !== 1'b0)
      $display("FAIL rst_read: got %h/%b want 0/0", data2axil, ctrl_enable);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      write_en     = ($urandom_range(0, 2) == 0);
      addr_write   = 8'($urandom_range(0, 7));
      data2native  = $urandom;
      read_en_sync = ($urandom_range(0, 1) == 0);
      addr_read    = 8'($urandom_range(0, 7));
      vsync        = ($urandom_range(0, 3) == 0);
      cycle();
      total++;
      if (data2axil !== m_rdata || irq !== m_irq || ctrl_enable !== m_ctrl[0] ||
          ctrl_test_pattern !== m_ctrl[1] || bg_color !== m_bg) begin
        $display("FAIL random[%0d]: got rd=%h irq=%b en=%b tp=%b bg=%h want rd=%h irq=%b en=%b tp=%b bg=%h",
                 i, data2axil, irq, ctrl_enable, ctrl_test_pattern, bg_color,
                 m_rdata, m_irq, m_ctrl[0], m_ctrl[1], m_bg);
      end else passed++;
    end
    write_en = 1'b0; read_en_sync = 1'b0; vsync = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_config();
    test_frames();
    test_same_cycle();
    test_w1c_race();
    test_wrap();
    test_rst_read();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
